// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the five-stage RV32I pipeline.
// Covers load-use, taken branches resolved in Execute, and multi-cycle data
// memory accesses with a watchdog that aborts a stuck access.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushF,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             mem_stall;
    logic             lw_stall;
    logic [1:0]       fwd_a, fwd_b;

    // Memory stage wins over Writeback since it holds the younger result; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs)      return 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        else                                            return 2'b00;
    endfunction

    // Operand forwarding selects and load-use detection.
    always_comb begin
        fwd_a    = fwd_sel(Rs1E);
        fwd_b    = fwd_sel(Rs2E);
        lw_stall = ResultSrcE0 && RdE != 5'd0 && (Rs1D == RdE || Rs2D == RdE);
    end

    // Memory access FSM next state; ready always beats the timeout check.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_stall  = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_stall = MemReqM & ~MemReadyM;
                if (mem_stall) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                mem_stall = ~MemReadyM;
                if (MemReadyM)                    state_d = S_IDLE;
                else if (wait_cnt_q == WAIT_LAST) state_d = S_ABORT;
                else                              wait_cnt_d = wait_cnt_q + WCW'(1);
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        mem_err_d = (state_d == S_ABORT);
    end

    // Stall/flush outputs; a memory stall freezes everything and overrides branch/load-use.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushF    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallD = lw_stall;
                // PC must still load the branch target when both hazards coincide.
                StallF = lw_stall & ~PCSrcE;
                FlushF = PCSrcE;
                FlushE = lw_stall | PCSrcE;
                FlushW = (state_q == S_ABORT);
            end
        end
    end

    // Performance counters, wrapping naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(StallF);
        flush_cnt_d = flush_cnt_q + CNT_W'(FlushF);
    end

    // State, watchdog, error pulse and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemErr     = mem_err_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushF, FlushE, FlushW, MemErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int nchk = 0;
    int nerr = 0;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushF(FlushF), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    // {StallF,StallD,StallE,StallM,FlushF,FlushE,FlushW,MemErr}
    wire [7:0] ctl = {StallF, StallD, StallE, StallM, FlushF, FlushE, FlushW, MemErr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    // advance one clock, land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with inputs that would otherwise drive outputs
        clr();
        rst = 1;
        PCSrcE = 1; RegWriteM = 1; RdM = 3; Rs1E = 3; MemReqM = 1;
        ResultSrcE0 = 1; RdE = 4; Rs1D = 4;
        #2;
        chk("rst_ctl", 32'(ctl), 32'h00);
        chk("rst_fwdA", 32'(ForwardAE), 32'd0);
        tick();
        chk("rst_ctl_clk", 32'(ctl), 32'h00);
        chk("rst_scnt", StallCount, 0);
        chk("rst_fcnt", FlushCount, 0);
        clr();
        rst = 0;
        #1;
        chk("idle_ctl", 32'(ctl), 32'h00);

        // load-use: lw x5 in E, Rs1D=5
        ResultSrcE0 = 1; RdE = 5; Rs1D = 5;
        #1;
        chk("lu_ctl", 32'(ctl), 32'b1100_0100);
        tick();
        clr();
        RdM = 5; RegWriteM = 1; Rs1E = 5;
        #1;
        chk("lu_next_ctl", 32'(ctl), 32'h00);
        chk("lu_fwdA", 32'(ForwardAE), 32'd2);
        chk("lu_scnt", StallCount, 1);
        chk("lu_fcnt", FlushCount, 0);

        // forward priority and x0
        clr();
        RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs2E = 7; Rs1E = 9;
        #1;
        chk("fwdB_prio", 32'(ForwardBE), 32'd2);
        chk("fwdA_none", 32'(ForwardAE), 32'd0);
        RegWriteM = 0;
        #1;
        chk("fwdB_w", 32'(ForwardBE), 32'd1);
        RegWriteM = 1; RdM = 0; RdW = 0; Rs2E = 0;
        #1;
        chk("fwdB_x0", 32'(ForwardBE), 32'd0);
        clr();
        ResultSrcE0 = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
        #1;
        chk("lu_x0_ctl", 32'(ctl), 32'h00);

        // branch together with load-use
        clr();
        ResultSrcE0 = 1; RdE = 6; Rs2D = 6; PCSrcE = 1;
        #1;
        chk("br_lu_ctl", 32'(ctl), 32'b0100_1100);
        tick();
        clr();
        #1;
        chk("br_fcnt", FlushCount, 1);
        chk("br_scnt", StallCount, 1);

        // memory wait of 3 cycles with a branch held in E
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_stall%0d", i), 32'(ctl), 32'b1111_0010);
            tick();
        end
        MemReadyM = 1;
        #1;
        chk("mw_release", 32'(ctl), 32'b0000_1100);
        chk("mw_scnt", StallCount, 4);
        tick();
        clr();
        #1;
        chk("mw_after", 32'(ctl), 32'h00);
        chk("mw_fcnt", FlushCount, 2);

        // timeout: ready never arrives
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < TIMEOUT + 1; i++) begin
            #1;
            chk($sformatf("to_stall%0d", i), 32'(ctl), 32'b1111_0010);
            tick();
        end
        #1;
        chk("to_abort", 32'(ctl), 32'b0000_0011);
        chk("to_scnt", StallCount, 9);
        tick();
        MemReqM = 0;
        #1;
        chk("to_idle", 32'(ctl), 32'h00);

        // reset in the middle of WAIT
        MemReqM = 1;
        tick();
        tick();
        #1;
        chk("rw_wait", 32'(ctl), 32'b1111_0010);
        rst = 1;
        #1;
        chk("rw_rst_ctl", 32'(ctl), 32'h00);
        chk("rw_rst_scnt", StallCount, 0);
        chk("rw_rst_fcnt", FlushCount, 0);
        tick();
        rst = 0;
        for (int i = 0; i < TIMEOUT + 1; i++) begin
            #1;
            chk($sformatf("rw_stall%0d", i), 32'(ctl), 32'b1111_0010);
            tick();
        end
        #1;
        chk("rw_abort", 32'(ctl), 32'b0000_0011);
        chk("rw_scnt", StallCount, TIMEOUT + 1);
        MemReqM = 0;
        tick();
        #1;
        chk("rw_noerr2", 32'(MemErr), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It generates every stall, flush and forwarding select for the F/D/E/M/W pipeline registers. It covers load-use hazards, taken branches/jumps resolved in Execute, and multi-cycle data-memory accesses through a ready handshake with a watchdog timeout. Two stall/flush event counters are provided for performance monitoring.

## Interface
Parameters:
- TIMEOUT, 16, number of WAIT cycles without MemReadyM before the access is aborted (≥2)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode
- Rs1E, Rs2E, RdE  in  5  sources/destination of the instruction in Execute
- ResultSrcE0  in  1  Execute instruction is a load
- PCSrcE  in  1  branch/jump taken in Execute
- RdM, RdW  in  5  destinations in Memory/Writeback
- RegWriteM, RegWriteW  in  1  register write enables in Memory/Writeback
- MemReqM  in  1  Memory-stage instruction accesses data memory
- MemReadyM  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold PC / F-D / D-E / E-M registers
- FlushF  out  1  clear F-D register (NOP)
- FlushE  out  1  clear D-E register
- FlushW  out  1  clear M-W register (bubble into Writeback)
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 W result, 10 M ALU result
- MemErr  out  1  one-cycle pulse on memory timeout abort
- StallCount, FlushCount  out  CNT_W  cycle counters

## Operation
- **Forwarding (combinational):** ForwardAE=10 if RegWriteM & RdM≠0 & RdM==Rs1E. Otherwise 01 if RegWriteW & RdW≠0 & RdW==Rs1E. Otherwise 00. Memory takes priority over Writeback. ForwardBE uses the same rule with Rs2E.
- **Load-use:** lwStall = ResultSrcE0 & RdE≠0 & (Rs1D==RdE | Rs2D==RdE).
- **Memory FSM (registered state):**
  - IDLE: memStall = MemReqM & ~MemReadyM. If memStall, go to WAIT with waitCnt=0.
  - WAIT: memStall = ~MemReadyM. If MemReadyM, go to IDLE. If ~MemReadyM and waitCnt==TIMEOUT-1, go to ABORT. Otherwise increment waitCnt.
  - ABORT: lasts exactly one cycle. memStall=0, MemErr=1, FlushW=1, MemReqM ignored. Next state is IDLE.
- **Output equations:**
  - memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushF=FlushE=0. Memory stall overrides load-use and branch. A branch held in E re-asserts its flush on the release cycle.
  - Otherwise: StallE=StallM=0 and FlushW=(state==ABORT). StallD=lwStall. StallF=lwStall & ~PCSrcE, so the PC is allowed to load the branch target. FlushF=PCSrcE. FlushE=lwStall | PCSrcE.
- **Counters:** StallCount increments every cycle StallF=1. FlushCount increments every cycle FlushF=1. Both wrap modulo 2^CNT_W.
- **Reset:** While rst is high, the FSM is forced to IDLE and waitCnt and both counters are 0. Every stall/flush output, MemErr and both forward selects are forced to 0. Reset asserted mid-WAIT abandons the access with no MemErr.

## Timing
- Forwarding, load-use, stall and flush outputs are combinational from inputs and FSM state, valid within the same cycle.
- Load-use produces exactly one stall cycle. The following cycle the load is in M, lwStall drops, and forwarding selects 10.
- Branch produces one cycle of FlushF/FlushE. Two fetched instructions are squashed.
- Memory miss with ready arriving k cycles after the request (k≥1) gives k stall cycles; MemReadyM=1 in the same cycle as the request gives 0 stall cycles.
- Timeout gives TIMEOUT+1 stall cycles, then one ABORT cycle with MemErr=1 and no stall.
- A MemErr pulse never occurs on two consecutive cycles.
- Counters update on the clock edge following the counted cycle.

## Test plan
- **Load-use:** lw x5 in E (RdE=5, ResultSrcE0=1), Rs1D=5 -> StallF=StallD=FlushE=1 for 1 cycle. The next cycle with RdM=5, RegWriteM=1, Rs1E=5 -> ForwardAE=10. StallCount increments by 1.
- **Forward priority and x0:** RdM=RdW=7, both writing, Rs2E=7 -> ForwardBE=10. RdM=RdW=0, Rs2E=0 -> ForwardBE=00. Load in E with RdE=0 -> no stall.
- **Branch with load-use:** PCSrcE=1 and lwStall=1 together -> StallF=0, StallD=1, FlushF=1, FlushE=1. FlushCount increments by 1.
- **Memory wait:** MemReqM=1, MemReadyM low for 3 cycles then high -> all Stall*=1 and FlushW=1 for exactly 3 cycles. PCSrcE=1 during the wait gives FlushF=0 until release. MemErr stays 0.
- **Timeout, TIMEOUT=4:** MemReqM=1, MemReadyM held 0 -> stall for 5 cycles, then one cycle with MemErr=1, FlushW=1 and stalls 0, then IDLE.
- **Reset mid-WAIT:** rst pulsed in WAIT -> outputs go to 0 immediately and counters clear. After release, a stuck request re-enters WAIT with waitCnt=0.
